cpu_ctrl: RTL and testbench

- Microcoded control sequencer for the 8-bit CPU; sits directly upstream of the ALU and drives its `alu_out` (result onto bus) and `alu_cut` (subtract) controls.
- Consumes the instruction register value and the ALU's `alu_cy`/`alu_z` outputs. Latches them into a flags register for conditional jumps.
- Steps each instruction through a fixed 5-state T-cycle (fetch T0–T1, execute T2–T4) and emits one-hot bus/register control strobes.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_ring.sv | 24 ++
 rtl/cpu_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU control sequencer: opcodes, T-state
// encoding and the bit layout of the 15-bit microcode control word.
package cpu_pkg;

  localparam int STEP_W = 3;
  localparam int CW_W   = 15;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_CO   = 0;
  localparam int CW_CE   = 1;
  localparam int CW_J    = 2;
  localparam int CW_MI   = 3;
  localparam int CW_RO   = 4;
  localparam int CW_RI   = 5;
  localparam int CW_II   = 6;
  localparam int CW_IO   = 7;
  localparam int CW_AI   = 8;
  localparam int CW_AO   = 9;
  localparam int CW_BI   = 10;
  localparam int CW_ALUO = 11;
  localparam int CW_CUT  = 12;
  localparam int CW_OI   = 13;
  localparam int CW_FI   = 14;

endpackage

// File: rtl/cpu_ring.sv
// T-state ring: counts T0..T4 and wraps, holds while frozen (halted),
// synchronous active-high reset back to T0.
module cpu_ring
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_freeze,
  output logic [STEP_W-1:0] o_step
);

  logic [STEP_W-1:0] r_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= T0;
    end else if (!i_freeze) begin
      r_step <= (r_step == T4) ? T0 : r_step + 3'd1;
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/cpu_ctrl.sv
// Microcoded control sequencer: decodes (T-state, opcode, flags) into one-hot
// bus/register strobes and keeps the carry/zero flags and the sticky halt bit.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int ARG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W+ARG_W-1:0] ctl_ir,
  input  logic                  alu_cy,
  input  logic                  alu_z,
  output logic                  ctl_co,
  output logic                  ctl_ce,
  output logic                  ctl_j,
  output logic                  ctl_mi,
  output logic                  ctl_ro,
  output logic                  ctl_ri,
  output logic                  ctl_ii,
  output logic                  ctl_io,
  output logic                  ctl_ai,
  output logic                  ctl_ao,
  output logic                  ctl_bi,
  output logic                  alu_out,
  output logic                  alu_cut,
  output logic                  ctl_oi,
  output logic                  ctl_fi,
  output logic                  flag_cy,
  output logic                  flag_z,
  output logic                  ctl_hlt,
  output logic [2:0]            ctl_step
);

  logic [STEP_W-1:0] w_step;
  logic [OP_W-1:0]   w_op;
  logic [CW_W-1:0]   w_cw;
  logic              w_hlt_set;
  logic              w_unused_arg;
  logic              r_halted;
  logic              r_flag_cy;
  logic              r_flag_z;

  assign w_op         = ctl_ir[OP_W+ARG_W-1:ARG_W];
  assign w_unused_arg = ^ctl_ir[ARG_W-1:0];

  cpu_ring u_ring (
    .clk      (clk),
    .rst      (rst),
    .i_freeze (r_halted),
    .o_step   (w_step)
  );

  // Reset and halt both mask the whole control word, so no strobe can leak.
  always_comb begin
    w_cw      = '0;
    w_hlt_set = 1'b0;
    if (!rst && !r_halted) begin
      case (w_step)
        T0: begin w_cw[CW_CO] = 1'b1; w_cw[CW_MI] = 1'b1; end
        T1: begin w_cw[CW_RO] = 1'b1; w_cw[CW_II] = 1'b1; w_cw[CW_CE] = 1'b1; end
        T2: begin
          case (w_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin w_cw[CW_IO] = 1'b1; w_cw[CW_MI] = 1'b1; end
            OP_LDI: begin w_cw[CW_IO] = 1'b1; w_cw[CW_AI] = 1'b1; end
            OP_JMP: begin w_cw[CW_IO] = 1'b1; w_cw[CW_J] = 1'b1; end
            OP_JC:  begin w_cw[CW_IO] = r_flag_cy; w_cw[CW_J] = r_flag_cy; end
            OP_JZ:  begin w_cw[CW_IO] = r_flag_z;  w_cw[CW_J] = r_flag_z;  end
            OP_OUT: begin w_cw[CW_AO] = 1'b1; w_cw[CW_OI] = 1'b1; end
            OP_HLT: w_hlt_set = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (w_op)
            OP_LDA:         begin w_cw[CW_RO] = 1'b1; w_cw[CW_AI] = 1'b1; end
            OP_ADD, OP_SUB: begin w_cw[CW_RO] = 1'b1; w_cw[CW_BI] = 1'b1; end
            OP_STA:         begin w_cw[CW_AO] = 1'b1; w_cw[CW_RI] = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (w_op == OP_ADD || w_op == OP_SUB) begin
            w_cw[CW_ALUO] = 1'b1;
            w_cw[CW_AI]   = 1'b1;
            w_cw[CW_FI]   = 1'b1;
            w_cw[CW_CUT]  = (w_op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // Flags capture the live ALU outputs only on the fi strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted  <= 1'b0;
      r_flag_cy <= 1'b0;
      r_flag_z  <= 1'b0;
    end else begin
      if (w_hlt_set) r_halted <= 1'b1;
      if (w_cw[CW_FI]) begin
        r_flag_cy <= alu_cy;
        r_flag_z  <= alu_z;
      end
    end
  end

  assign ctl_co   = w_cw[CW_CO];
  assign ctl_ce   = w_cw[CW_CE];
  assign ctl_j    = w_cw[CW_J];
  assign ctl_mi   = w_cw[CW_MI];
  assign ctl_ro   = w_cw[CW_RO];
  assign ctl_ri   = w_cw[CW_RI];
  assign ctl_ii   = w_cw[CW_II];
  assign ctl_io   = w_cw[CW_IO];
  assign ctl_ai   = w_cw[CW_AI];
  assign ctl_ao   = w_cw[CW_AO];
  assign ctl_bi   = w_cw[CW_BI];
  assign alu_out  = w_cw[CW_ALUO];
  assign alu_cut  = w_cw[CW_CUT];
  assign ctl_oi   = w_cw[CW_OI];
  assign ctl_fi   = w_cw[CW_FI];
  assign flag_cy  = r_flag_cy;
  assign flag_z   = r_flag_z;
  assign ctl_hlt  = r_halted;
  assign ctl_step = w_step;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: walks instructions T-state by T-state and
// checks strobes, step, flags and halt against hand-written expectations.
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ctl_ir;
  logic       alu_cy, alu_z;
  logic ctl_co, ctl_ce, ctl_j, ctl_mi, ctl_ro, ctl_ri, ctl_ii, ctl_io;
  logic ctl_ai, ctl_ao, ctl_bi, alu_out, alu_cut, ctl_oi, ctl_fi;
  logic flag_cy, flag_z, ctl_hlt;
  logic [2:0] ctl_step;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [14:0] S_CO = 15'h4000, S_CE = 15'h2000, S_J   = 15'h1000;
  localparam logic [14:0] S_MI = 15'h0800, S_RO = 15'h0400, S_RI  = 15'h0200;
  localparam logic [14:0] S_II = 15'h0100, S_IO = 15'h0080, S_AI  = 15'h0040;
  localparam logic [14:0] S_AO = 15'h0020, S_BI = 15'h0010, S_ALU = 15'h0008;
  localparam logic [14:0] S_CUT = 15'h0004, S_OI = 15'h0002, S_FI = 15'h0001;
  localparam logic [14:0] S_NONE = 15'h0000;
  localparam logic [14:0] F_T0 = S_CO | S_MI;
  localparam logic [14:0] F_T1 = S_RO | S_II | S_CE;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk(clk), .rst(rst), .ctl_ir(ctl_ir), .alu_cy(alu_cy), .alu_z(alu_z),
    .ctl_co(ctl_co), .ctl_ce(ctl_ce), .ctl_j(ctl_j), .ctl_mi(ctl_mi),
    .ctl_ro(ctl_ro), .ctl_ri(ctl_ri), .ctl_ii(ctl_ii), .ctl_io(ctl_io),
    .ctl_ai(ctl_ai), .ctl_ao(ctl_ao), .ctl_bi(ctl_bi), .alu_out(alu_out),
    .alu_cut(alu_cut), .ctl_oi(ctl_oi), .ctl_fi(ctl_fi), .flag_cy(flag_cy),
    .flag_z(flag_z), .ctl_hlt(ctl_hlt), .ctl_step(ctl_step)
  );

  function automatic logic [14:0] strobes();
    return {ctl_co, ctl_ce, ctl_j, ctl_mi, ctl_ro, ctl_ri, ctl_ii, ctl_io,
            ctl_ai, ctl_ao, ctl_bi, alu_out, alu_cut, ctl_oi, ctl_fi};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one T-state (step and strobe word), then advance one clock.
  task automatic tstep(input string tag, input logic [2:0] es, input logic [14:0] ew);
    chk({tag, "_step"}, {12'd0, ctl_step}, {12'd0, es});
    chk({tag, "_strb"}, strobes(), ew);
    tick();
  endtask

  task automatic chk_flags(input string tag, input logic ecy, input logic ez);
    chk(tag, {13'd0, flag_cy, flag_z}, {13'd0, ecy, ez});
  endtask

  initial begin
    rst = 1'b1; ctl_ir = 8'h00; alu_cy = 1'b0; alu_z = 1'b0;
    tick();
    chk("rst_strb", strobes(), S_NONE);
    chk("rst_step", {12'd0, ctl_step}, 15'd0);
    chk("rst_hlt", {14'd0, ctl_hlt}, 15'd0);
    chk_flags("rst_flags", 1'b0, 1'b0);
    rst = 1'b0;
    #1;

    // NOP free-run
    tstep("nop_t0", 3'd0, F_T0);
    tstep("nop_t1", 3'd1, F_T1);
    tstep("nop_t2", 3'd2, S_NONE);
    tstep("nop_t3", 3'd3, S_NONE);
    tstep("nop_t4", 3'd4, S_NONE);
    chk("nop_wrap", {12'd0, ctl_step}, 15'd0);
    chk_flags("nop_flags", 1'b0, 1'b0);

    // ADD 0x2A, carry out with nonzero 9-bit result
    ctl_ir = 8'h2A; alu_cy = 1'b1; alu_z = 1'b0; #1;
    tstep("add_t0", 3'd0, F_T0);
    tstep("add_t1", 3'd1, F_T1);
    tstep("add_t2", 3'd2, S_IO | S_MI);
    tstep("add_t3", 3'd3, S_RO | S_BI);
    chk_flags("add_pre_flags", 1'b0, 1'b0);
    tstep("add_t4", 3'd4, S_ALU | S_AI | S_FI);
    chk_flags("add_flags", 1'b1, 1'b0);

    // SUB 0x3A, no borrow, zero result
    ctl_ir = 8'h3A; alu_cy = 1'b0; alu_z = 1'b1; #1;
    tstep("sub_t0", 3'd0, F_T0);
    tstep("sub_t1", 3'd1, F_T1);
    tstep("sub_t2", 3'd2, S_IO | S_MI);
    tstep("sub_t3", 3'd3, S_RO | S_BI);
    tstep("sub_t4", 3'd4, S_ALU | S_CUT | S_AI | S_FI);
    chk_flags("sub_flags", 1'b0, 1'b1);

    // Conditional jumps use registered flags; live ALU inputs are the opposite
    ctl_ir = 8'h85; alu_cy = 1'b1; alu_z = 1'b0; #1;
    tick(); tick();
    tstep("jz_taken_t2", 3'd2, S_IO | S_J);
    tick(); tick();
    chk_flags("jz_flags_hold", 1'b0, 1'b1);
    ctl_ir = 8'h75; #1;
    tick(); tick();
    tstep("jc_not_t2", 3'd2, S_NONE);
    tick(); tick();

    // Flip flags to cy=1, z=0 with another ADD
    ctl_ir = 8'h21; alu_cy = 1'b1; alu_z = 1'b0; #1;
    repeat (5) tick();
    chk_flags("add2_flags", 1'b1, 1'b0);
    alu_cy = 1'b0; alu_z = 1'b1;
    ctl_ir = 8'h85; #1;
    tick(); tick();
    tstep("jz_not_t2", 3'd2, S_NONE);
    tick(); tick();
    ctl_ir = 8'h75; #1;
    tick(); tick();
    tstep("jc_taken_t2", 3'd2, S_IO | S_J);
    tick(); tick();

    // Remaining opcodes
    ctl_ir = 8'h13; #1;
    tick(); tick();
    tstep("lda_t2", 3'd2, S_IO | S_MI);
    tstep("lda_t3", 3'd3, S_RO | S_AI);
    tstep("lda_t4", 3'd4, S_NONE);
    ctl_ir = 8'h4C; #1;
    tick(); tick();
    tstep("sta_t2", 3'd2, S_IO | S_MI);
    tstep("sta_t3", 3'd3, S_AO | S_RI);
    tstep("sta_t4", 3'd4, S_NONE);
    ctl_ir = 8'h57; #1;
    tick(); tick();
    tstep("ldi_t2", 3'd2, S_IO | S_AI);
    tstep("ldi_t3", 3'd3, S_NONE);
    tick();
    ctl_ir = 8'h69; #1;
    tick(); tick();
    tstep("jmp_t2", 3'd2, S_IO | S_J);
    tick(); tick();
    ctl_ir = 8'hE0; #1;
    tick(); tick();
    tstep("out_t2", 3'd2, S_AO | S_OI);
    tick(); tick();
    ctl_ir = 8'h9F; #1;
    tick(); tick();
    tstep("undef_t2", 3'd2, S_NONE);
    tstep("undef_t3", 3'd3, S_NONE);
    tstep("undef_t4", 3'd4, S_NONE);
    chk_flags("undef_flags", 1'b1, 1'b0);

    // HLT freezes at T3 with all strobes low until reset
    ctl_ir = 8'hF0; #1;
    tstep("hlt_t0", 3'd0, F_T0);
    tstep("hlt_t1", 3'd1, F_T1);
    chk("hlt_t2_nothalted", {14'd0, ctl_hlt}, 15'd0);
    tstep("hlt_t2", 3'd2, S_NONE);
    chk("hlt_set", {14'd0, ctl_hlt}, 15'd1);
    for (int i = 0; i < 11; i++) begin
      tstep("hlt_frz", 3'd3, S_NONE);
    end
    chk("hlt_sticky", {14'd0, ctl_hlt}, 15'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("hlt_clr", {14'd0, ctl_hlt}, 15'd0);
    chk("hlt_rst_step", {12'd0, ctl_step}, 15'd0);
    chk_flags("hlt_rst_flags", 1'b0, 1'b0);

    // Reset in the middle of an ADD
    ctl_ir = 8'h2A; alu_cy = 1'b1; alu_z = 1'b1; #1;
    tick(); tick(); tick();
    chk("mid_at_t3", {12'd0, ctl_step}, 15'd3);
    rst = 1'b1; #1;
    chk("mid_rst_strb", strobes(), S_NONE);
    tick();
    rst = 1'b0; #1;
    chk_flags("mid_flags", 1'b0, 1'b0);
    tstep("mid_t0", 3'd0, F_T0);
    tstep("mid_t1", 3'd1, F_T1);
    chk_flags("mid_flags2", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
